// File: rtl/ace_snoop_buffer.sv
// ACE snoop channel buffer between the interconnect (AC/CR/CD) and the dcache snoop port.
// Queues AC requests, keeps a single snoop outstanding, registers CR, skid-buffers CD, and runs a watchdog.
module ace_snoop_buffer #(
  parameter int AcDepth       = 4,
  parameter int AddrWidth     = 64,
  parameter int DataWidth     = 64,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  logic [3:0]           ac_snoop_i,
  input  logic [2:0]           ac_prot_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output logic [4:0]           cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 cache_ac_valid_o,
  input  logic                 cache_ac_ready_i,
  output logic [AddrWidth-1:0] cache_ac_addr_o,
  output logic [3:0]           cache_ac_snoop_o,
  output logic [2:0]           cache_ac_prot_o,
  input  logic                 cache_cr_valid_i,
  output logic                 cache_cr_ready_o,
  input  logic [4:0]           cache_cr_resp_i,
  input  logic                 cache_cd_valid_i,
  output logic                 cache_cd_ready_o,
  input  logic [DataWidth-1:0] cache_cd_data_i,
  input  logic                 cache_cd_last_i,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int PtrW = $clog2(AcDepth);
  localparam int CntW = PtrW + 1;
  localparam int EntW = AddrWidth + 7;
  localparam int WdW  = $clog2(TimeoutCycles);
  localparam logic [WdW-1:0] WdMax  = WdW'(TimeoutCycles - 1);
  localparam logic [WdW-1:0] WdFire = WdW'(TimeoutCycles - 2);

  logic [EntW-1:0]      ac_mem_q [AcDepth];
  logic [EntW-1:0]      ac_mem_d [AcDepth];
  logic [PtrW-1:0]      ac_wr_q, ac_wr_d, ac_rd_q, ac_rd_d;
  logic [CntW-1:0]      ac_cnt_q, ac_cnt_d;
  logic                 outst_q, outst_d;
  logic                 cr_seen_q, cr_seen_d;
  logic                 last_seen_q, last_seen_d;
  logic                 need_data_q, need_data_d;
  logic                 cr_valid_q, cr_valid_d;
  logic [4:0]           cr_resp_q, cr_resp_d;
  logic [DataWidth-1:0] cd_data_q [2];
  logic [DataWidth-1:0] cd_data_d [2];
  logic [1:0]           cd_last_q, cd_last_d;
  logic                 cd_wr_q, cd_wr_d, cd_rd_q, cd_rd_d;
  logic [1:0]           cd_cnt_q, cd_cnt_d;
  logic [WdW-1:0]       wd_cnt_q, wd_cnt_d;
  logic                 timeout_q, timeout_d;

  logic ac_full, ac_empty, ac_push, ac_pop;
  logic cr_take, cd_push, cd_pop, snoop_done;

  // Ready is taken from the registered count only, so a full FIFO never accepts even while popping.
  assign ac_full          = (ac_cnt_q == CntW'(AcDepth));
  assign ac_empty         = (ac_cnt_q == '0);
  assign ac_ready_o       = ~ac_full;
  assign ac_push          = ac_valid_i & ~ac_full;
  assign cache_ac_valid_o = ~ac_empty & ~outst_q;
  assign ac_pop           = cache_ac_valid_o & cache_ac_ready_i;
  assign {cache_ac_addr_o, cache_ac_snoop_o, cache_ac_prot_o} = ac_mem_q[ac_rd_q];

  assign cache_cr_ready_o = outst_q & ~cr_seen_q & ~cr_valid_q;
  assign cr_take          = cache_cr_ready_o & cache_cr_valid_i;
  assign cr_valid_o       = cr_valid_q;
  assign cr_resp_o        = cr_resp_q;

  assign cache_cd_ready_o = outst_q & ~last_seen_q & (cd_cnt_q != 2'd2);
  assign cd_push          = cache_cd_ready_o & cache_cd_valid_i;
  assign cd_valid_o       = (cd_cnt_q != 2'd0);
  assign cd_pop           = cd_valid_o & cd_ready_i;
  assign cd_data_o        = cd_data_q[cd_rd_q];
  assign cd_last_o        = cd_last_q[cd_rd_q];

  // Data is only awaited when the captured response announced a transfer.
  assign snoop_done = outst_q & cr_seen_q & (~need_data_q | last_seen_q);
  assign busy_o     = ~ac_empty | outst_q | cr_valid_q | cd_valid_o;
  assign timeout_o  = timeout_q;

  always_comb begin
    ac_mem_d = ac_mem_q;
    ac_wr_d  = ac_wr_q;
    ac_rd_d  = ac_rd_q;
    if (ac_push) begin
      ac_mem_d[ac_wr_q] = {ac_addr_i, ac_snoop_i, ac_prot_i};
      ac_wr_d           = ac_wr_q + PtrW'(1);
    end
    if (ac_pop) begin
      ac_rd_d = ac_rd_q + PtrW'(1);
    end
    ac_cnt_d = ac_cnt_q + CntW'(ac_push) - CntW'(ac_pop);
  end

  always_comb begin
    outst_d     = outst_q;
    cr_seen_d   = cr_seen_q;
    last_seen_d = last_seen_q;
    need_data_d = need_data_q;
    cr_valid_d  = cr_valid_q;
    cr_resp_d   = cr_resp_q;
    if (snoop_done) begin
      outst_d = 1'b0;
    end
    if (ac_pop) begin
      outst_d     = 1'b1;
      cr_seen_d   = 1'b0;
      last_seen_d = 1'b0;
    end
    if (cr_valid_q && cr_ready_i) begin
      cr_valid_d = 1'b0;
    end
    if (cr_take) begin
      cr_valid_d  = 1'b1;
      cr_seen_d   = 1'b1;
      cr_resp_d   = cache_cr_resp_i;
      need_data_d = cache_cr_resp_i[0];
    end
    if (cd_push && cache_cd_last_i) begin
      last_seen_d = 1'b1;
    end
  end

  always_comb begin
    cd_data_d = cd_data_q;
    cd_last_d = cd_last_q;
    cd_wr_d   = cd_wr_q;
    cd_rd_d   = cd_rd_q;
    if (cd_push) begin
      cd_data_d[cd_wr_q] = cache_cd_data_i;
      cd_last_d[cd_wr_q] = cache_cd_last_i;
      cd_wr_d            = ~cd_wr_q;
    end
    if (cd_pop) begin
      cd_rd_d = ~cd_rd_q;
    end
    cd_cnt_d = cd_cnt_q + 2'(cd_push) - 2'(cd_pop);
  end

  // Saturating watchdog; the pulse fires on the single transition into the last count.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = outst_q & (wd_cnt_q == WdFire);
    if (!outst_q || ac_pop) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WdMax) begin
      wd_cnt_d = wd_cnt_q + WdW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < AcDepth; i++) ac_mem_q[i] <= '0;
      ac_wr_q     <= '0;
      ac_rd_q     <= '0;
      ac_cnt_q    <= '0;
      outst_q     <= 1'b0;
      cr_seen_q   <= 1'b0;
      last_seen_q <= 1'b0;
      need_data_q <= 1'b0;
      cr_valid_q  <= 1'b0;
      cr_resp_q   <= '0;
      cd_data_q[0] <= '0;
      cd_data_q[1] <= '0;
      cd_last_q   <= '0;
      cd_wr_q     <= 1'b0;
      cd_rd_q     <= 1'b0;
      cd_cnt_q    <= '0;
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      ac_mem_q    <= ac_mem_d;
      ac_wr_q     <= ac_wr_d;
      ac_rd_q     <= ac_rd_d;
      ac_cnt_q    <= ac_cnt_d;
      outst_q     <= outst_d;
      cr_seen_q   <= cr_seen_d;
      last_seen_q <= last_seen_d;
      need_data_q <= need_data_d;
      cr_valid_q  <= cr_valid_d;
      cr_resp_q   <= cr_resp_d;
      cd_data_q   <= cd_data_d;
      cd_last_q   <= cd_last_d;
      cd_wr_q     <= cd_wr_d;
      cd_rd_q     <= cd_rd_d;
      cd_cnt_q    <= cd_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ace_snoop_buffer.sv
// Directed bench for ace_snoop_buffer: single snoops, FIFO fill, CR back-pressure,
// early CD data, watchdog pulse and asynchronous reset mid-snoop.
module tb_ace_snoop_buffer;

  logic        clk_i;
  logic        rst_ni;
  logic        ac_valid_i;
  logic        ac_ready_o;
  logic [63:0] ac_addr_i;
  logic [3:0]  ac_snoop_i;
  logic [2:0]  ac_prot_i;
  logic        cr_valid_o;
  logic        cr_ready_i;
  logic [4:0]  cr_resp_o;
  logic        cd_valid_o;
  logic        cd_ready_i;
  logic [63:0] cd_data_o;
  logic        cd_last_o;
  logic        cache_ac_valid_o;
  logic        cache_ac_ready_i;
  logic [63:0] cache_ac_addr_o;
  logic [3:0]  cache_ac_snoop_o;
  logic [2:0]  cache_ac_prot_o;
  logic        cache_cr_valid_i;
  logic        cache_cr_ready_o;
  logic [4:0]  cache_cr_resp_i;
  logic        cache_cd_valid_i;
  logic        cache_cd_ready_o;
  logic [63:0] cache_cd_data_i;
  logic        cache_cd_last_i;
  logic        busy_o;
  logic        timeout_o;

  int n_checks;
  int n_fail;

  ace_snoop_buffer #(
    .AcDepth(4), .AddrWidth(64), .DataWidth(64), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
    .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .cache_ac_valid_o(cache_ac_valid_o), .cache_ac_ready_i(cache_ac_ready_i),
    .cache_ac_addr_o(cache_ac_addr_o), .cache_ac_snoop_o(cache_ac_snoop_o),
    .cache_ac_prot_o(cache_ac_prot_o),
    .cache_cr_valid_i(cache_cr_valid_i), .cache_cr_ready_o(cache_cr_ready_o),
    .cache_cr_resp_i(cache_cr_resp_i),
    .cache_cd_valid_i(cache_cd_valid_i), .cache_cd_ready_o(cache_cd_ready_o),
    .cache_cd_data_i(cache_cd_data_i), .cache_cd_last_i(cache_cd_last_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [63:0] addr, input logic [3:0] snoop,
                               input logic [2:0] prot);
    ac_valid_i = valid;
    ac_addr_i  = addr;
    ac_snoop_i = snoop;
    ac_prot_i  = prot;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 64'h0, 4'h0, 3'h0);
    cr_ready_i       = 1'b0;
    cd_ready_i       = 1'b0;
    cache_ac_ready_i = 1'b0;
    cache_cr_valid_i = 1'b0;
    cache_cr_resp_i  = 5'b0;
    cache_cd_valid_i = 1'b0;
    cache_cd_data_i  = 64'h0;
    cache_cd_last_i  = 1'b0;
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_ni   = 1'b0;
    idleInputs();
    repeat (3) tick();
    checkOutput("rst ac_ready", 64'(ac_ready_o), 64'd1);
    checkOutput("rst busy", 64'(busy_o), 64'd0);
    checkOutput("rst cr_valid", 64'(cr_valid_o), 64'd0);
    checkOutput("rst cd_valid", 64'(cd_valid_o), 64'd0);
    checkOutput("rst cache_ac_valid", 64'(cache_ac_valid_o), 64'd0);
    checkOutput("rst cache_cr_ready", 64'(cache_cr_ready_o), 64'd0);
    checkOutput("rst cache_cd_ready", 64'(cache_cd_ready_o), 64'd0);
    checkOutput("rst timeout", 64'(timeout_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    $display("[TB] single ReadShared snoop with two data beats");
    applyStimulus(1'b1, 64'h8000_0040, 4'b0001, 3'b000);
    cache_ac_ready_i = 1'b1;
    tick();
    applyStimulus(1'b0, 64'h0, 4'h0, 3'h0);
    checkOutput("t1 issue valid", 64'(cache_ac_valid_o), 64'd1);
    checkOutput("t1 issue addr", cache_ac_addr_o, 64'h8000_0040);
    checkOutput("t1 issue snoop", 64'(cache_ac_snoop_o), 64'd1);
    tick();
    checkOutput("t1 cr_ready", 64'(cache_cr_ready_o), 64'd1);
    checkOutput("t1 single outstanding", 64'(cache_ac_valid_o), 64'd0);
    cache_ac_ready_i = 1'b0;
    cache_cr_valid_i = 1'b1;
    cache_cr_resp_i  = 5'b00001;
    tick();
    checkOutput("t1 cr_valid", 64'(cr_valid_o), 64'd1);
    checkOutput("t1 cr_resp", 64'(cr_resp_o), 64'h01);
    cache_cr_valid_i = 1'b0;
    cr_ready_i       = 1'b1;
    cache_cd_valid_i = 1'b1;
    cache_cd_data_i  = 64'h1111;
    cache_cd_last_i  = 1'b0;
    tick();
    checkOutput("t1 cr drained", 64'(cr_valid_o), 64'd0);
    checkOutput("t1 beat1 valid", 64'(cd_valid_o), 64'd1);
    checkOutput("t1 beat1 data", cd_data_o, 64'h1111);
    checkOutput("t1 beat1 last", 64'(cd_last_o), 64'd0);
    cache_cd_data_i = 64'h2222;
    cache_cd_last_i = 1'b1;
    tick();
    checkOutput("t1 cd_ready after last", 64'(cache_cd_ready_o), 64'd0);
    checkOutput("t1 head still beat1", cd_data_o, 64'h1111);
    cache_cd_valid_i = 1'b0;
    cd_ready_i       = 1'b1;
    tick();
    checkOutput("t1 beat2 data", cd_data_o, 64'h2222);
    checkOutput("t1 beat2 last", 64'(cd_last_o), 64'd1);
    checkOutput("t1 busy draining", 64'(busy_o), 64'd1);
    tick();
    checkOutput("t1 cd empty", 64'(cd_valid_o), 64'd0);
    checkOutput("t1 idle", 64'(busy_o), 64'd0);
    idleInputs();

    $display("[TB] fill the AC FIFO, then issue in order");
    applyStimulus(1'b1, 64'h100, 4'h1, 3'h0);
    tick();
    applyStimulus(1'b1, 64'h200, 4'h1, 3'h0);
    tick();
    applyStimulus(1'b1, 64'h300, 4'h1, 3'h0);
    tick();
    checkOutput("t2 ready at 3", 64'(ac_ready_o), 64'd1);
    applyStimulus(1'b1, 64'h400, 4'h1, 3'h0);
    tick();
    checkOutput("t2 full", 64'(ac_ready_o), 64'd0);
    checkOutput("t2 head valid", 64'(cache_ac_valid_o), 64'd1);
    applyStimulus(1'b1, 64'h500, 4'h1, 3'h0);
    tick();
    checkOutput("t2 fifth stalls a", 64'(ac_ready_o), 64'd0);
    tick();
    checkOutput("t2 fifth stalls b", 64'(ac_ready_o), 64'd0);
    applyStimulus(1'b0, 64'h0, 4'h0, 3'h0);
    cache_ac_ready_i = 1'b1;
    cache_cr_valid_i = 1'b1;
    cache_cr_resp_i  = 5'b00000;
    cr_ready_i       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2 issue%0d valid", i), 64'(cache_ac_valid_o), 64'd1);
      checkOutput($sformatf("t2 issue%0d addr", i), cache_ac_addr_o, 64'((i + 1) * 'h100));
      tick();
      checkOutput($sformatf("t2 issue%0d held", i), 64'(cache_ac_valid_o), 64'd0);
      checkOutput($sformatf("t2 issue%0d room", i), 64'(ac_ready_o), 64'd1);
      tick();
      checkOutput($sformatf("t2 issue%0d cr", i), 64'(cr_valid_o), 64'd1);
      tick();
    end
    checkOutput("t2 no fifth entry", 64'(cache_ac_valid_o), 64'd0);
    checkOutput("t2 idle", 64'(busy_o), 64'd0);
    idleInputs();

    $display("[TB] dataless CR held by interconnect back-pressure");
    applyStimulus(1'b1, 64'hA00, 4'h7, 3'h2);
    cache_ac_ready_i = 1'b1;
    tick();
    applyStimulus(1'b1, 64'hB00, 4'h7, 3'h2);
    tick();
    applyStimulus(1'b0, 64'h0, 4'h0, 3'h0);
    checkOutput("t3 cr_ready", 64'(cache_cr_ready_o), 64'd1);
    cache_cr_valid_i = 1'b1;
    cache_cr_resp_i  = 5'b00000;
    tick();
    checkOutput("t3 hold1 valid", 64'(cr_valid_o), 64'd1);
    checkOutput("t3 hold1 resp", 64'(cr_resp_o), 64'h00);
    cache_cr_resp_i = 5'b01000;
    tick();
    checkOutput("t3 hold2 valid", 64'(cr_valid_o), 64'd1);
    checkOutput("t3 hold2 resp", 64'(cr_resp_o), 64'h00);
    checkOutput("t3 next issue valid", 64'(cache_ac_valid_o), 64'd1);
    checkOutput("t3 next issue addr", cache_ac_addr_o, 64'hB00);
    checkOutput("t3 no cd", 64'(cd_valid_o), 64'd0);
    tick();
    checkOutput("t3 hold3 valid", 64'(cr_valid_o), 64'd1);
    checkOutput("t3 hold3 resp", 64'(cr_resp_o), 64'h00);
    checkOutput("t3 second cr blocked", 64'(cache_cr_ready_o), 64'd0);
    cr_ready_i = 1'b1;
    tick();
    checkOutput("t3 first drained", 64'(cr_valid_o), 64'd0);
    checkOutput("t3 second cr open", 64'(cache_cr_ready_o), 64'd1);
    tick();
    checkOutput("t3 second cr valid", 64'(cr_valid_o), 64'd1);
    checkOutput("t3 second cr resp", 64'(cr_resp_o), 64'h08);
    cache_cr_valid_i = 1'b0;
    tick();
    checkOutput("t3 idle", 64'(busy_o), 64'd0);
    checkOutput("t3 no cd end", 64'(cd_valid_o), 64'd0);
    idleInputs();

    $display("[TB] data beats ahead of the response");
    applyStimulus(1'b1, 64'hC00, 4'h1, 3'h0);
    cache_ac_ready_i = 1'b1;
    tick();
    applyStimulus(1'b0, 64'h0, 4'h0, 3'h0);
    tick();
    cache_ac_ready_i = 1'b0;
    applyStimulus(1'b1, 64'hD00, 4'h9, 3'h1);
    cache_cd_valid_i = 1'b1;
    cache_cd_data_i  = 64'hA5A5_A5A5_A5A5_A5A5;
    cache_cd_last_i  = 1'b0;
    checkOutput("t4 cd_ready empty", 64'(cache_cd_ready_o), 64'd1);
    tick();
    applyStimulus(1'b0, 64'h0, 4'h0, 3'h0);
    cache_cd_data_i = 64'h5A5A_5A5A_5A5A_5A5A;
    tick();
    checkOutput("t4 cd_ready full", 64'(cache_cd_ready_o), 64'd0);
    checkOutput("t4 head beat1", cd_data_o, 64'hA5A5_A5A5_A5A5_A5A5);
    cache_cd_data_i = 64'hA5A5_A5A5_0000_0003;
    cache_cd_last_i = 1'b1;
    tick();
    checkOutput("t4 still full", 64'(cache_cd_ready_o), 64'd0);
    checkOutput("t4 no cr yet", 64'(cr_valid_o), 64'd0);
    checkOutput("t4 waits for cr", 64'(cache_ac_valid_o), 64'd0);
    checkOutput("t4 cr_ready", 64'(cache_cr_ready_o), 64'd1);
    cache_cr_valid_i = 1'b1;
    cache_cr_resp_i  = 5'b00001;
    tick();
    checkOutput("t4 cr_valid", 64'(cr_valid_o), 64'd1);
    checkOutput("t4 cr_resp", 64'(cr_resp_o), 64'h01);
    checkOutput("t4 waits for last", 64'(cache_ac_valid_o), 64'd0);
    cache_cr_valid_i = 1'b0;
    cd_ready_i       = 1'b1;
    tick();
    checkOutput("t4 head beat2", cd_data_o, 64'h5A5A_5A5A_5A5A_5A5A);
    checkOutput("t4 room again", 64'(cache_cd_ready_o), 64'd1);
    tick();
    checkOutput("t4 head beat3", cd_data_o, 64'hA5A5_A5A5_0000_0003);
    checkOutput("t4 beat3 last", 64'(cd_last_o), 64'd1);
    checkOutput("t4 last seen", 64'(cache_cd_ready_o), 64'd0);
    checkOutput("t4 still outstanding", 64'(cache_ac_valid_o), 64'd0);
    cache_cd_valid_i = 1'b0;
    tick();
    checkOutput("t4 cd drained", 64'(cd_valid_o), 64'd0);
    checkOutput("t4 cr still held", 64'(cr_valid_o), 64'd1);
    checkOutput("t4 completion issue", 64'(cache_ac_valid_o), 64'd1);
    checkOutput("t4 queued addr", cache_ac_addr_o, 64'hD00);
    cr_ready_i = 1'b1;
    tick();
    checkOutput("t4 cr drained", 64'(cr_valid_o), 64'd0);
    checkOutput("t4 busy with queue", 64'(busy_o), 64'd1);
    cr_ready_i = 1'b0;
    cd_ready_i = 1'b0;

    $display("[TB] watchdog on a silent cache");
    cache_ac_ready_i = 1'b1;
    tick();
    cache_ac_ready_i = 1'b0;
    checkOutput("t5 issued", 64'(cache_cr_ready_o), 64'd1);
    checkOutput("t5 no early pulse 0", 64'(timeout_o), 64'd0);
    for (int i = 1; i < 15; i++) begin
      tick();
      checkOutput($sformatf("t5 no early pulse %0d", i), 64'(timeout_o), 64'd0);
    end
    tick();
    checkOutput("t5 pulse", 64'(timeout_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("t5 no repeat %0d", i), 64'(timeout_o), 64'd0);
    end
    checkOutput("t5 not aborted", 64'(cache_cr_ready_o), 64'd1);
    cache_cr_valid_i = 1'b1;
    cache_cr_resp_i  = 5'b00000;
    cr_ready_i       = 1'b1;
    tick();
    checkOutput("t5 late cr", 64'(cr_valid_o), 64'd1);
    cache_cr_valid_i = 1'b0;
    tick();
    checkOutput("t5 cr drained", 64'(cr_valid_o), 64'd0);
    checkOutput("t5 idle", 64'(busy_o), 64'd0);
    checkOutput("t5 no pulse after", 64'(timeout_o), 64'd0);
    idleInputs();

    $display("[TB] asynchronous reset mid-snoop");
    applyStimulus(1'b1, 64'hE00, 4'h1, 3'h0);
    cache_ac_ready_i = 1'b1;
    tick();
    applyStimulus(1'b1, 64'hF00, 4'h1, 3'h0);
    tick();
    applyStimulus(1'b1, 64'h1000, 4'h1, 3'h0);
    cache_ac_ready_i = 1'b0;
    cache_cr_valid_i = 1'b1;
    cache_cr_resp_i  = 5'b00001;
    tick();
    applyStimulus(1'b0, 64'h0, 4'h0, 3'h0);
    cache_cr_valid_i = 1'b0;
    cache_cd_valid_i = 1'b1;
    cache_cd_data_i  = 64'hDEAD;
    tick();
    checkOutput("t6 cr pending", 64'(cr_valid_o), 64'd1);
    checkOutput("t6 cd pending", 64'(cd_valid_o), 64'd1);
    checkOutput("t6 busy", 64'(busy_o), 64'd1);
    checkOutput("t6 outstanding", 64'(cache_ac_valid_o), 64'd0);
    cache_cd_valid_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("t6 async cr_valid", 64'(cr_valid_o), 64'd0);
    checkOutput("t6 async cd_valid", 64'(cd_valid_o), 64'd0);
    checkOutput("t6 async busy", 64'(busy_o), 64'd0);
    checkOutput("t6 async ac_ready", 64'(ac_ready_o), 64'd1);
    checkOutput("t6 async cache_ac_valid", 64'(cache_ac_valid_o), 64'd0);
    checkOutput("t6 async cache_cr_ready", 64'(cache_cr_ready_o), 64'd0);
    checkOutput("t6 async cache_cd_ready", 64'(cache_cd_ready_o), 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    checkOutput("t6 post ac_ready", 64'(ac_ready_o), 64'd1);
    checkOutput("t6 post busy", 64'(busy_o), 64'd0);
    tick();
    checkOutput("t6 post cache_ac_valid", 64'(cache_ac_valid_o), 64'd0);
    checkOutput("t6 post cr_valid", 64'(cr_valid_o), 64'd0);
    checkOutput("t6 post cd_valid", 64'(cd_valid_o), 64'd0);
    checkOutput("t6 post busy 2", 64'(busy_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
